// File: rtl/alu_muldiv_pkg.sv
// Shared constants and types for the ALU / multiply-divide execute block.
// Holds the ALU_OP codes used by the controller, the MD_OP codes that
// select the iterative multiply/divide operation, and the FSM state type.
package alu_muldiv_pkg;

    // Combinational ALU operation codes; any code not listed performs SLL.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_NOP = 4'd15;

    // Multiply/divide operation codes.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Signed variants work on operand magnitudes and fix the signs at the end.
    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_muldiv_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a, b              operands (a is also the MTHI/MTLO data)
//   md_start, md_op   request and operation select
//   hi_we, lo_we      MTHI / MTLO write enables, honoured only when idle
//   md_busy, md_done  unit iterating / one-cycle completion pulse
//   hi, lo            HI and LO registers
// One accumulator serves both operations: the upper half holds the partial
// product (multiply) or the running remainder (divide); the lower half holds
// the multiplier being consumed (multiply) or the dividend being turned into
// the quotient (divide).
module muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    md_state_t          state_r, state_next_s;
    logic               accept_s;

    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   op_r;
    logic [CW-1:0]      count_r;
    logic               is_div_r;
    logic               sign_q_r;
    logic               sign_r_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               op_signed_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;

    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_shift_s;
    logic               rem_ge_s;
    logic [WIDTH-1:0]   rem_diff_s;
    logic [2*WIDTH-1:0] acc_step_s;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a START outside IDLE is simply not looked at.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (md_start) begin
                    state_next_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_ZERO) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand magnitudes captured at START for the signed operations.
    always_comb begin
        op_signed_s = md_is_signed(md_op);
        if (op_signed_s && a[WIDTH-1]) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (op_signed_s && b[WIDTH-1]) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        acc_hi_s    = acc_r[2*WIDTH-1:WIDTH];
        acc_lo_s    = acc_r[WIDTH-1:0];
        mul_sum_s   = {1'b0, acc_hi_s} + (acc_lo_s[0] ? {1'b0, op_r} : {(WIDTH+1){1'b0}});
        rem_shift_s = {acc_hi_s, acc_lo_s[WIDTH-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, op_r});
        // The difference is only kept when it is below the divisor, so WIDTH bits suffice.
        rem_diff_s  = rem_shift_s[WIDTH-1:0] - op_r;
        if (is_div_r) begin
            if (rem_ge_s) begin
                acc_step_s = {rem_diff_s, acc_lo_s[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_shift_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_lo_s[WIDTH-1:1]};
        end
    end

    // Sign correction applied while in FIX.
    always_comb begin
        if (sign_q_r) begin
            prod_s = -acc_r;
        end else begin
            prod_s = acc_r;
        end
        // A zero divisor yields an all-ones quotient magnitude; leave it uncorrected.
        if (sign_q_r && !b_zero_r) begin
            quo_s = -acc_lo_s;
        end else begin
            quo_s = acc_lo_s;
        end
        if (sign_r_r) begin
            rem_s = -acc_hi_s;
        end else begin
            rem_s = acc_hi_s;
        end
        if (is_div_r) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Iteration datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            op_r     <= {WIDTH{1'b0}};
            count_r  <= CNT_ZERO;
            is_div_r <= 1'b0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            b_zero_r <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // MTHI/MTLO land now even if a START is accepted alongside.
                    if (hi_we) begin
                        hi_r <= a;
                    end
                    if (lo_we) begin
                        lo_r <= a;
                    end
                    if (accept_s) begin
                        acc_r    <= {{WIDTH{1'b0}}, a_mag_s};
                        op_r     <= b_mag_s;
                        count_r  <= CNT_LOAD;
                        is_div_r <= md_op[1];
                        sign_q_r <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r_r <= (md_op == MD_DIV) & a[WIDTH-1];
                        b_zero_r <= (b == {WIDTH{1'b0}});
                        busy_r   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r   <= acc_step_s;
                    count_r <= count_r - CNT_ONE;
                end
                FIX: begin
                    hi_r   <= fix_hi_s;
                    lo_r   <= fix_lo_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy = busy_r;
    assign md_done = done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with an attached iterative multiply/divide unit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   A, B, ALU_OP      operands and combinational op select
//   ALU_OUT           combinational ALU result
//   MD_START, MD_OP   multiply/divide request and operation
//   MD_BUSY, MD_DONE  unit iterating / one-cycle completion pulse
//   HI_WE, LO_WE      MTHI / MTLO write enables (data from A)
//   HI, LO            HI and LO registers
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_OP,
    output logic [WIDTH-1:0] ALU_OUT,
    input  logic             MD_START,
    input  logic [1:0]       MD_OP,
    output logic             MD_BUSY,
    output logic             MD_DONE,
    input  logic             HI_WE,
    input  logic             LO_WE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt_s;
    logic           slt_s;

    assign shamt_s = A[SHW-1:0];
    assign slt_s   = ($signed(A) < $signed(B));

    // Combinational operation mux; unknown codes and NOP fall through to SLL.
    always_comb begin
        ALU_OUT = B << shamt_s;
        case (ALU_OP)
            ALU_ADD: ALU_OUT = A + B;
            ALU_SUB: ALU_OUT = A - B;
            ALU_AND: ALU_OUT = A & B;
            ALU_OR:  ALU_OUT = A | B;
            ALU_NOR: ALU_OUT = ~(A | B);
            ALU_SLT: ALU_OUT = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SRL: ALU_OUT = B >> shamt_s;
            ALU_SRA: ALU_OUT = $signed(B) >>> shamt_s;
            ALU_SLL: ALU_OUT = B << shamt_s;
            default: ALU_OUT = B << shamt_s;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv_iter (
        .clk      (clk),
        .rst      (rst),
        .a        (A),
        .b        (B),
        .md_start (MD_START),
        .md_op    (MD_OP),
        .hi_we    (HI_WE),
        .lo_we    (LO_WE),
        .md_busy  (MD_BUSY),
        .md_done  (MD_DONE),
        .hi       (HI),
        .lo       (LO)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: table-driven ALU and mul/div vectors
// plus hand-written sequences for busy, reset and HI/LO write corner cases.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic [3:0]  ALU_OP = 4'd0;
    logic [31:0] ALU_OUT;
    logic        MD_START = 1'b0;
    logic [1:0]  MD_OP = 2'd0;
    logic        MD_BUSY, MD_DONE;
    logic        HI_WE = 1'b0, LO_WE = 1'b0;
    logic [31:0] HI, LO;

    // 16-bit instance, used only for its combinational ALU.
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] out16, hi16, lo16;
    logic        start16 = 1'b0, hiwe16 = 1'b0, lowe16 = 1'b0;
    logic [1:0]  mdop16 = 2'd0;
    logic        busy16, done16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALU_OP(ALU_OP), .ALU_OUT(ALU_OUT),
        .MD_START(MD_START), .MD_OP(MD_OP), .MD_BUSY(MD_BUSY), .MD_DONE(MD_DONE),
        .HI_WE(HI_WE), .LO_WE(LO_WE), .HI(HI), .LO(LO)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .ALU_OP(op16), .ALU_OUT(out16),
        .MD_START(start16), .MD_OP(mdop16), .MD_BUSY(busy16), .MD_DONE(done16),
        .HI_WE(hiwe16), .LO_WE(lowe16), .HI(hi16), .LO(lo16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_vec_t;

    alu_vec_t alu_tab[14];
    md_vec_t  md_tab[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic md_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        A = a; B = b; MD_OP = op; MD_START = 1'b1;
        tick();
        MD_START = 1'b0;
    endtask

    // Cycles from the START edge until DONE is seen; 100 means it never came.
    task automatic md_wait(output int lat);
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (MD_DONE) break;
        end
    endtask

    initial begin
        int lat;
        int dones;
        int done_at;

        alu_tab[0]  = '{ALU_ADD, 32'd5,          32'd7,          32'd12};
        alu_tab[1]  = '{ALU_ADD, 32'hFFFFFFFF,   32'd1,          32'd0};
        alu_tab[2]  = '{ALU_SUB, 32'd3,          32'd5,          32'hFFFFFFFE};
        alu_tab[3]  = '{ALU_AND, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000};
        alu_tab[4]  = '{ALU_OR,  32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0};
        alu_tab[5]  = '{ALU_NOR, 32'h0000FFFF,   32'h00FF0000,   32'hFF000000};
        alu_tab[6]  = '{ALU_SLT, 32'hFFFFFFFF,   32'd1,          32'd1};
        alu_tab[7]  = '{ALU_SLT, 32'd1,          32'hFFFFFFFF,   32'd0};
        alu_tab[8]  = '{ALU_SLT, 32'h7FFFFFFF,   32'h80000000,   32'd0};
        alu_tab[9]  = '{ALU_SRL, 32'd4,          32'h80000000,   32'h08000000};
        alu_tab[10] = '{ALU_SRA, 32'd4,          32'h80000000,   32'hF8000000};
        alu_tab[11] = '{ALU_SRA, 32'd1,          32'h7FFFFFFE,   32'h3FFFFFFF};
        alu_tab[12] = '{ALU_SLL, 32'h00000024,   32'd1,          32'h00000010};
        alu_tab[13] = '{ALU_NOP, 32'd31,         32'd1,          32'h80000000};

        md_tab[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        md_tab[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        md_tab[2] = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
        md_tab[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        md_tab[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        md_tab[5] = '{MD_DIVU,  32'h00000010, 32'd0,        32'h00000010, 32'hFFFFFFFF};
        md_tab[6] = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        md_tab[7] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_hi",   HI, 32'd0);
        check("reset_lo",   LO, 32'd0);
        check("reset_busy", {31'd0, MD_BUSY}, 32'd0);
        check("reset_done", {31'd0, MD_DONE}, 32'd0);

        // Combinational ALU vectors.
        for (int i = 0; i < 14; i++) begin
            ALU_OP = alu_tab[i].op; A = alu_tab[i].a; B = alu_tab[i].b;
            #1;
            check($sformatf("alu_%0d", i), ALU_OUT, alu_tab[i].exp);
        end
        a16 = 16'h0013; b16 = 16'h8000; op16 = ALU_SRA;
        #1;
        check("alu16_sra", {16'd0, out16}, 32'h0000F000);

        // Mul/div vectors, each started in the DONE cycle of the previous one.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) check($sformatf("md_%0d_done_at_start", i), {31'd0, MD_DONE}, 32'd1);
            md_issue(md_tab[i].op, md_tab[i].a, md_tab[i].b);
            check($sformatf("md_%0d_busy", i), {31'd0, MD_BUSY}, 32'd1);
            md_wait(lat);
            check($sformatf("md_%0d_latency", i), lat, 32'd33);
            check($sformatf("md_%0d_hi", i), HI, md_tab[i].hi);
            check($sformatf("md_%0d_lo", i), LO, md_tab[i].lo);
        end

        // MTHI while idle, then a busy op that sees stray STARTs and an HI_WE.
        tick();
        A = 32'h00005555; HI_WE = 1'b1;
        tick();
        HI_WE = 1'b0;
        check("mthi", HI, 32'h00005555);
        md_issue(MD_MULTU, 32'd6, 32'd7);
        dones = 0;
        done_at = 0;
        for (int c = 1; c <= 60; c++) begin
            MD_START = (c == 5 || c == 20);
            HI_WE    = (c == 10);
            MD_OP    = MD_DIV;
            A        = (c == 10) ? 32'h0000DEAD : 32'h00000100;
            B        = 32'd3;
            tick();
            if (MD_DONE) begin
                dones++;
                done_at = c;
            end
            if (c == 10) check("hi_we_busy", HI, 32'h00005555);
            if (c == 20) check("busy_after_stray_start", {31'd0, MD_BUSY}, 32'd1);
        end
        MD_START = 1'b0; HI_WE = 1'b0;
        check("stray_done_count", dones, 32'd1);
        check("stray_done_at",    done_at, 32'd33);
        check("stray_hi", HI, 32'd0);
        check("stray_lo", LO, 32'd42);

        // Reset in the middle of RUN.
        md_issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hi",   HI, 32'd0);
        check("rst_mid_lo",   LO, 32'd0);
        check("rst_mid_busy", {31'd0, MD_BUSY}, 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (MD_DONE) dones++;
            tick();
        end
        check("rst_mid_no_done", dones, 32'd0);

        // MTLO while idle.
        A = 32'h00001234; LO_WE = 1'b1;
        tick();
        LO_WE = 1'b0;
        check("mtlo_lo", LO, 32'h00001234);
        check("mtlo_hi", HI, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
